// File: rtl/id_issue_ctrl.sv
// Decode-stage issue/stall/flush control with a 32-entry pending-write scoreboard; issue and stall decisions are same-cycle (combinational), while the scoreboard and error state register on the clock edge.
// A hazard holds PC and IF/ID until WB releases the register. Define HAZARD_PERF_CNT_EN to add the stall_cycles counter.
module id_issue_ctrl #(
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_regwrite,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic        ex_redirect,
    output logic        issue,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [31:0] sb_pending,
    output logic        hazard_err,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_VAL = 8'(STALL_TIMEOUT);

    state_t      state, state_nxt;
    logic [2:0]  flush_cnt, flush_cnt_nxt;
    logic [7:0]  stall_run, stall_run_nxt;
    logic [31:0] release_vec, set_vec, pend_eff;
    logic        hazard;

    // Write-through register file: a register retiring in WB this cycle is already readable.
    always_comb begin
        release_vec = wb_regwrite ? (32'd1 << wb_rd) : 32'd0;
        pend_eff    = sb_pending & ~release_vec;
        hazard      = id_valid & ((id_use_rs1 & pend_eff[id_rs1]) |
                                  (id_use_rs2 & pend_eff[id_rs2]) |
                                  (id_regwrite & pend_eff[id_rd]));
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        issue         = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b1;
        if (!rst_n) begin
            if_id_flush   = 1'b1;
            state_nxt     = RUN;
            flush_cnt_nxt = 3'd0;
        end else begin
            case (state)
                FLUSH: begin
                    if_id_flush = 1'b1;
                    if (ex_redirect) begin
                        flush_cnt_nxt = FLUSH_LOAD;
                    end else if (flush_cnt == 3'd0) begin
                        state_nxt = RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 3'd1;
                    end
                end
                default: begin
                    if (ex_redirect) begin
                        if_id_flush   = 1'b1;
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_LOAD;
                    end else if (hazard) begin
                        if_id_stall = 1'b1;
                        state_nxt   = STALL;
                    end else begin
                        issue        = id_valid;
                        id_ex_bubble = ~id_valid;
                        state_nxt    = RUN;
                    end
                end
            endcase
        end
    end

    always_comb begin
        set_vec = (issue & id_regwrite & (id_rd != 5'd0)) ? (32'd1 << id_rd) : 32'd0;
        if (state_nxt == STALL) begin
            stall_run_nxt = (stall_run == 8'hFF) ? stall_run : stall_run + 8'd1;
        end else begin
            stall_run_nxt = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_cnt  <= 3'd0;
            stall_run  <= 8'd0;
            sb_pending <= 32'd0;
            hazard_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_cnt  <= flush_cnt_nxt;
            stall_run  <= stall_run_nxt;
            sb_pending <= (pend_eff | set_vec) & ~32'd1;
            if ((state_nxt == STALL) && (stall_run_nxt == TIMEOUT_VAL)) begin
                hazard_err <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt <= 32'd0;
        end else if (if_id_stall) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign stall_cycles = perf_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
